// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file and the decode/hazard logic.
// Default geometry and the INIT/RUN state encoding live here so every consumer agrees.
// Optional write-to-read bypass is selected by the RF_BYPASS_EN macro in the top.
package reg_file_mp_pkg;

    localparam int RF_DATA_W_DEF = 16;
    localparam int RF_ADDR_W_DEF = 4;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Purpose: per-register busy flags; decode sets a flag, writeback clears it.
// Latency: flags update on the rising edge, visible the following cycle.
// Backpressure: none; set and clear are accepted every cycle, set wins on the same address.
module rf_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] r_busy;

    // Set has priority over clear: a newly issued producer supersedes the retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_set && (sb_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Purpose: parametrised N_RD-read / 1-write register file with init sweep, ready flag and busy scoreboard.
// Latency: combinational reads; writes visible next cycle (same cycle when RF_BYPASS_EN is defined).
// Backpressure: none; reads return 0 and writes/sets are dropped until ready rises.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic                     ready
);

    localparam int NUM_REGS = 2**ADDR_W;

    rf_state_e          r_state;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_ready;
    logic [DATA_W-1:0]  r_mem [NUM_REGS];

    logic w_run;
    logic w_wr_en;
    logic w_sb_set;

    // Writeback and issue are only honoured once the sweep has finished; a cycle
    // with rst high never commits a write.
    assign w_run    = (r_state == RF_RUN);
    assign w_wr_en  = wr_en  & w_run & ~rst;
    assign w_sb_set = sb_set & w_run & ~rst;

    // Init sweep FSM: one entry cleared per cycle, RUN is entered after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else if (r_state == RF_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                r_state <= RF_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // Storage: the sweep owns the array in INIT, writeback owns it in RUN.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Independent read muxes, forced to zero until the file is usable.
    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_word;

        assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        assign w_word = (w_wr_en && (wr_addr == w_addr)) ? wr_data : r_mem[w_addr];
`else
        assign w_word = r_mem[w_addr];
`endif
        assign rd_data[p*DATA_W +: DATA_W] = w_run ? w_word : '0;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .sb_set  (w_sb_set),
        .sb_addr (sb_addr),
        .wr_en   (w_wr_en),
        .wr_addr (wr_addr),
        .busy    (busy)
    );

    assign ready = r_ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 16x16/2-port instance plus a 32x32/3-port instance.
// Expected read values during a same-cycle write follow the RF_BYPASS_EN build option.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: DATA_W=16, ADDR_W=4, N_RD=2
    logic        rst;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        sb_set;
    logic [3:0]  sb_addr;
    logic [15:0] busy;
    logic        ready;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy), .ready(ready)
    );

    // Wide instance: DATA_W=32, ADDR_W=5, N_RD=3
    logic        b_rst;
    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_sb_set;
    logic [4:0]  b_sb_addr;
    logic [31:0] b_busy;
    logic        b_ready;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(3)) dut_b (
        .clk(clk), .rst(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr), .busy(b_busy), .ready(b_ready)
    );

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0;
        b_rst = 1'b1; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_sb_set = 1'b0; b_sb_addr = '0;

        // 1. reset two cycles, then 16-edge sweep with ready low and reads forced to 0
        tick(); tick();
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_ready", 64'(ready), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            #1;
            check("init_ready_low", 64'(ready), 64'h0);
            check("init_rd_zero", 64'(rd_data), 64'h0);
            tick();
        end
        check("ready_after_16", 64'(ready), 64'h1);
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            #1;
            check("swept_zero", 64'(rd_data), 64'h0);
            tick();
        end

        // 2. write r5, read r5/r3 next cycle
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr = {4'd3, 4'd5};
        #1;
        check("r5_same_cycle", 64'(rd_data[15:0]), BYP ? 64'hBEEF : 64'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("r5_port0", 64'(rd_data[15:0]), 64'hBEEF);
        check("r3_port1", 64'(rd_data[31:16]), 64'h0);

        // 3. write r7 while both ports read r7
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234; rd_addr = {4'd7, 4'd7};
        #1;
        check("r7_bypass_p0", 64'(rd_data[15:0]), BYP ? 64'h1234 : 64'h0);
        check("r7_bypass_p1", 64'(rd_data[31:16]), BYP ? 64'h1234 : 64'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("r7_next", 64'(rd_data), 64'h1234_1234);

        // register 0 is a normal register
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0; rd_addr = {4'd5, 4'd0};
        #1;
        check("r0_writable", 64'(rd_data), 64'hBEEF_5A5A);

        // 4. scoreboard set / set-wins / independent set+clear / clear
        sb_set = 1'b1; sb_addr = 4'd9;
        tick();
        sb_set = 1'b0;
        check("busy9_set", 64'(busy), 64'h0200);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909; sb_set = 1'b1; sb_addr = 4'd9;
        tick();
        check("busy9_set_wins", 64'(busy), 64'h0200);
        wr_en = 1'b1; wr_addr = 4'd9; sb_set = 1'b1; sb_addr = 4'd4;
        tick();
        check("set4_clr9", 64'(busy), 64'h0010);
        sb_set = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0404;
        tick();
        wr_en = 1'b0;
        check("clr4", 64'(busy), 64'h0000);

        // 5. mid-run reset wipes busy, ready and contents
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h00AA; sb_set = 1'b1; sb_addr = 4'd1;
        tick();
        wr_en = 1'b0; sb_set = 1'b0; rd_addr = {4'd2, 4'd2};
        #1;
        check("r2_written", 64'(rd_data), 64'h00AA_00AA);
        check("busy1_before_rst", 64'(busy), 64'h0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_rd_zero", 64'(rd_data), 64'h0);
        for (int i = 0; i < 9; i++) tick();

        // 6. pulses during INIT are ignored (r0 already swept at edge 1)
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; sb_set = 1'b1; sb_addr = 4'd0;
        tick();
        wr_en = 1'b0; sb_set = 1'b0;
        check("init_busy_ignored", 64'(busy), 64'h0);
        for (int i = 0; i < 5; i++) tick();
        check("reinit_ready_low_15", 64'(ready), 64'h0);
        tick();
        check("reinit_ready_16", 64'(ready), 64'h1);
        rd_addr = {4'd2, 4'd0};
        #1;
        check("reinit_r2_r0_zero", 64'(rd_data), 64'h0);
        check("reinit_busy", 64'(busy), 64'h0);

        // wide instance: 32-entry sweep, 3 ports, 32-bit data
        b_rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("b_init_ready_low", 64'(b_ready), 64'h0);
            tick();
        end
        check("b_ready_after_32", 64'(b_ready), 64'h1);
        b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 32'hDEADBEEF;
        tick();
        b_wr_addr = 5'd0; b_wr_data = 32'h0000_0001; b_rd_addr = {5'd0, 5'd31, 5'd31};
        #1;
        check("b_p0_r31", 64'(b_rd_data[31:0]), 64'hDEADBEEF);
        check("b_p1_r31", 64'(b_rd_data[63:32]), 64'hDEADBEEF);
        check("b_p2_r0_same", 64'(b_rd_data[95:64]), BYP ? 64'h1 : 64'h0);
        tick();
        b_wr_en = 1'b0;
        #1;
        check("b_p2_r0_next", 64'(b_rd_data[95:64]), 64'h1);
        b_sb_set = 1'b1; b_sb_addr = 5'd17;
        tick();
        b_sb_set = 1'b0;
        check("b_busy17", 64'(b_busy), 64'h0002_0000);
        b_wr_en = 1'b1; b_wr_addr = 5'd17; b_sb_set = 1'b1; b_sb_addr = 5'd17;
        tick();
        b_sb_set = 1'b0;
        check("b_busy17_set_wins", 64'(b_busy), 64'h0002_0000);
        tick();
        b_wr_en = 1'b0;
        check("b_busy17_clr", 64'(b_busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
